// File: rtl/instr_encoder.sv
// RV32I (+CLZ/CTZ/CPOP) instruction encoder: the inverse of the decode stage.
// The package carries the operation list and opcode/funct constants shared with decode.
// The module is a two-stage valid/ready pipeline with immediate range checks,
// a write-address counter and a saturating error counter.

package riscv_pkg;
    localparam int XLEN = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_B    = 3'b000;
    localparam logic [2:0] F3_H    = 3'b001;
    localparam logic [2:0] F3_W    = 3'b010;
    localparam logic [2:0] F3_BU   = 3'b100;
    localparam logic [2:0] F3_HU   = 3'b101;

    localparam logic [6:0] F7_BASE  = 7'b0000000;
    localparam logic [6:0] F7_ALT   = 7'b0100000;
    localparam logic [6:0] F7_COUNT = 7'b0110000;

    typedef enum logic [5:0] {
        UNKNOWN,
        LUI, AUIPC, JAL, JALR,
        BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LB, LH, LW, LBU, LHU,
        SB, SH, SW,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI,
        SLLI, SRLI, SRAI,
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        CLZ, CTZ, CPOP
    } operation_e;
endpackage

module instr_encoder
    import riscv_pkg::*;
#(
    parameter int                 ADDR_W    = 12,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  operation_e        operation_i,
    input  logic [4:0]        rd_addr_i,
    input  logic [4:0]        rs1_addr_i,
    input  logic [4:0]        rs2_addr_i,
    input  logic [XLEN-1:0]   imm_i,
    input  logic [4:0]        shamt_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [XLEN-1:0]   instr_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              err_o,
    output logic [15:0]       err_cnt_o
);

    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        FMT_NONE, FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J
    } fmt_e;

    fmt_e       fmt;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] fld5;     // bits [24:20]: rs2, shamt or the count selector

    logic              s1_valid_q;
    logic [XLEN-1:0]   s1_instr_q, s1_instr_d;
    logic              s1_err_q, s1_err_d;
    logic              out_valid_q;
    logic [XLEN-1:0]   instr_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       err_cnt_q;

    logic s2_adv, s1_adv, in_accept, out_hs;
    logic i_ok, b_ok, j_ok, u_ok;

    assign s2_adv     = !out_valid_q || out_ready_i;
    assign s1_adv     = !s1_valid_q || s2_adv;
    assign in_ready_o = s1_adv && !flush_i && !rst_i;
    assign in_accept  = in_valid_i && in_ready_o;
    assign out_hs     = out_valid_q && out_ready_i;

    // Immediate must survive truncation to its field (sign bits all equal, alignment).
    assign i_ok = (&imm_i[31:11]) || !(|imm_i[31:11]);
    assign b_ok = ((&imm_i[31:12]) || !(|imm_i[31:12])) && !imm_i[0];
    assign j_ok = ((&imm_i[31:20]) || !(|imm_i[31:20])) && !imm_i[0];
    assign u_ok = !(|imm_i[11:0]);

    // Map the operation to its format and opcode/funct fields.
    always_comb begin
        fmt  = FMT_NONE;
        opc  = '0;
        f3   = '0;
        f7   = F7_BASE;
        fld5 = rs2_addr_i;
        case (operation_i)
            LUI:   begin fmt = FMT_U; opc = OPC_LUI;   end
            AUIPC: begin fmt = FMT_U; opc = OPC_AUIPC; end
            JAL:   begin fmt = FMT_J; opc = OPC_JAL;   end
            JALR:  begin fmt = FMT_I; opc = OPC_JALR; f3 = 3'b000; end
            BEQ:   begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BEQ;  end
            BNE:   begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BNE;  end
            BLT:   begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BLT;  end
            BGE:   begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BGE;  end
            BLTU:  begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BLTU; end
            BGEU:  begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BGEU; end
            LB:    begin fmt = FMT_I; opc = OPC_LOAD; f3 = F3_B;  end
            LH:    begin fmt = FMT_I; opc = OPC_LOAD; f3 = F3_H;  end
            LW:    begin fmt = FMT_I; opc = OPC_LOAD; f3 = F3_W;  end
            LBU:   begin fmt = FMT_I; opc = OPC_LOAD; f3 = F3_BU; end
            LHU:   begin fmt = FMT_I; opc = OPC_LOAD; f3 = F3_HU; end
            SB:    begin fmt = FMT_S; opc = OPC_STORE; f3 = F3_B; end
            SH:    begin fmt = FMT_S; opc = OPC_STORE; f3 = F3_H; end
            SW:    begin fmt = FMT_S; opc = OPC_STORE; f3 = F3_W; end
            ADDI:  begin fmt = FMT_I; opc = OPC_OP_IMM; f3 = F3_ADD;  end
            SLTI:  begin fmt = FMT_I; opc = OPC_OP_IMM; f3 = F3_SLT;  end
            SLTIU: begin fmt = FMT_I; opc = OPC_OP_IMM; f3 = F3_SLTU; end
            XORI:  begin fmt = FMT_I; opc = OPC_OP_IMM; f3 = F3_XOR;  end
            ORI:   begin fmt = FMT_I; opc = OPC_OP_IMM; f3 = F3_OR;   end
            ANDI:  begin fmt = FMT_I; opc = OPC_OP_IMM; f3 = F3_AND;  end
            // Immediate shifts are R-shaped with shamt in the rs2 slot.
            SLLI:  begin fmt = FMT_R; opc = OPC_OP_IMM; f3 = F3_SLL; fld5 = shamt_i; end
            SRLI:  begin fmt = FMT_R; opc = OPC_OP_IMM; f3 = F3_SR;  fld5 = shamt_i; end
            SRAI:  begin fmt = FMT_R; opc = OPC_OP_IMM; f3 = F3_SR;  fld5 = shamt_i; f7 = F7_ALT; end
            ADD:   begin fmt = FMT_R; opc = OPC_OP; f3 = F3_ADD;  end
            SUB:   begin fmt = FMT_R; opc = OPC_OP; f3 = F3_ADD;  f7 = F7_ALT; end
            SLL:   begin fmt = FMT_R; opc = OPC_OP; f3 = F3_SLL;  end
            SLT:   begin fmt = FMT_R; opc = OPC_OP; f3 = F3_SLT;  end
            SLTU:  begin fmt = FMT_R; opc = OPC_OP; f3 = F3_SLTU; end
            XOR:   begin fmt = FMT_R; opc = OPC_OP; f3 = F3_XOR;  end
            SRL:   begin fmt = FMT_R; opc = OPC_OP; f3 = F3_SR;   end
            SRA:   begin fmt = FMT_R; opc = OPC_OP; f3 = F3_SR;   f7 = F7_ALT; end
            OR:    begin fmt = FMT_R; opc = OPC_OP; f3 = F3_OR;   end
            AND:   begin fmt = FMT_R; opc = OPC_OP; f3 = F3_AND;  end
            // Bit-count ops select the variant through the rs2 slot.
            CLZ:   begin fmt = FMT_R; opc = OPC_OP_IMM; f3 = F3_SLL; f7 = F7_COUNT; fld5 = 5'd0; end
            CTZ:   begin fmt = FMT_R; opc = OPC_OP_IMM; f3 = F3_SLL; f7 = F7_COUNT; fld5 = 5'd1; end
            CPOP:  begin fmt = FMT_R; opc = OPC_OP_IMM; f3 = F3_SLL; f7 = F7_COUNT; fld5 = 5'd2; end
            default: fmt = FMT_NONE;
        endcase
    end

    // Assemble the machine word; out-of-range immediates still encode their low bits.
    always_comb begin
        s1_instr_d = NOP;
        s1_err_d   = 1'b1;
        case (fmt)
            FMT_R: begin
                s1_instr_d = {f7, fld5, rs1_addr_i, f3, rd_addr_i, opc};
                s1_err_d   = 1'b0;
            end
            FMT_I: begin
                s1_instr_d = {imm_i[11:0], rs1_addr_i, f3, rd_addr_i, opc};
                s1_err_d   = !i_ok;
            end
            FMT_S: begin
                s1_instr_d = {imm_i[11:5], rs2_addr_i, rs1_addr_i, f3, imm_i[4:0], opc};
                s1_err_d   = !i_ok;
            end
            FMT_B: begin
                s1_instr_d = {imm_i[12], imm_i[10:5], rs2_addr_i, rs1_addr_i, f3,
                              imm_i[4:1], imm_i[11], opc};
                s1_err_d   = !b_ok;
            end
            FMT_U: begin
                s1_instr_d = {imm_i[31:12], rd_addr_i, opc};
                s1_err_d   = !u_ok;
            end
            FMT_J: begin
                s1_instr_d = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_addr_i, opc};
                s1_err_d   = !j_ok;
            end
            default: begin
                s1_instr_d = NOP;
                s1_err_d   = 1'b1;
            end
        endcase
    end

    // Two-stage pipeline; flush drops both valids but leaves data registers alone.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q  <= 1'b0;
            s1_instr_q  <= '0;
            s1_err_q    <= 1'b0;
            out_valid_q <= 1'b0;
            instr_q     <= '0;
            err_q       <= 1'b0;
        end else if (flush_i) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            if (s2_adv) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    instr_q <= s1_instr_q;
                    err_q   <= s1_err_q;
                end
            end
            if (s1_adv) begin
                s1_valid_q <= in_accept;
                if (in_accept) begin
                    s1_instr_q <= s1_instr_d;
                    s1_err_q   <= s1_err_d;
                end
            end
        end
    end

    // Address and error counters advance on every consumed word, flush or not.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q    <= BASE_ADDR;
            err_cnt_q <= '0;
        end else if (out_hs) begin
            addr_q <= addr_q + ADDR_W'(4);
            if (err_q && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign instr_o     = instr_q;
    assign err_o       = err_q;
    assign addr_o      = addr_q;
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: expected words are queued on accept and
// popped on each output handshake.
module tb_instr_encoder;
    import riscv_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i, flush_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i, err_o;
    operation_e  operation_i;
    logic [4:0]  rd_addr_i, rs1_addr_i, rs2_addr_i, shamt_i;
    logic [31:0] imm_i, instr_o;
    logic [11:0] addr_o;
    logic [15:0] err_cnt_o;

    instr_encoder #(.ADDR_W(12), .BASE_ADDR(12'h000)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .operation_i(operation_i), .rd_addr_i(rd_addr_i), .rs1_addr_i(rs1_addr_i),
        .rs2_addr_i(rs2_addr_i), .imm_i(imm_i), .shamt_i(shamt_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .instr_o(instr_o), .addr_o(addr_o), .err_o(err_o), .err_cnt_o(err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        operation_e  op;
        logic [4:0]  rd, rs1, rs2, sh;
        logic [31:0] imm;
        logic [31:0] w;
        logic        e;
    } vec_t;

    typedef struct {
        logic [31:0] w;
        logic        e;
    } exp_t;

    exp_t        exp_q[$];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [11:0] m_addr = 12'h000;
    int          m_err  = 0;

    function automatic vec_t mk(operation_e op, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                                logic [31:0] imm, logic [4:0] sh, logic [31:0] w, logic e);
        vec_t v;
        v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.sh = sh; v.w = w; v.e = e;
        return v;
    endfunction

    task automatic drive(input vec_t v, input logic vld, input logic rdy, input logic fl);
        operation_i = v.op;  rd_addr_i = v.rd; rs1_addr_i = v.rs1; rs2_addr_i = v.rs2;
        imm_i       = v.imm; shamt_i   = v.sh;
        in_valid_i  = vld;   out_ready_i = rdy; flush_i = fl;
    endtask

    // Settle, then book-keep the coming edge: pop on output handshake, push on accept.
    task automatic sample(input vec_t pv, output logic acc, output logic oh,
                          output exp_t pe, output logic [11:0] ae);
        exp_t n;
        #1;
        acc  = in_valid_i && in_ready_o;
        oh   = out_valid_o && out_ready_i;
        ae   = m_addr;
        pe.w = 32'hDEAD_BEEF;
        pe.e = 1'bx;
        if (oh) begin
            if (exp_q.size() > 0) pe = exp_q.pop_front();
            m_addr = m_addr + 12'd4;
            if (pe.e === 1'b1 && m_err < 65535) m_err++;
        end
        if (acc) begin
            n.w = pv.w; n.e = pv.e;
            exp_q.push_back(n);
        end
    endtask

    task automatic test_reset();
        vec_t idle;
        idle = mk(UNKNOWN, 0, 0, 0, 0, 0, 0, 0);
        rst_i = 1'b1;
        drive(idle, 1'b1, 1'b1, 1'b0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        n_vec++; if (in_ready_o !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready got %b want 0", in_ready_o); end
        n_vec++; if (out_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid_o); end
        n_vec++; if (instr_o !== 32'h0) begin n_bad++; $display("FAIL reset_instr got %h want 0", instr_o); end
        n_vec++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", err_o); end
        n_vec++; if (addr_o !== 12'h000) begin n_bad++; $display("FAIL reset_addr got %h want 000", addr_o); end
        n_vec++; if (err_cnt_o !== 16'h0) begin n_bad++; $display("FAIL reset_errcnt got %0d want 0", err_cnt_o); end
        rst_i = 1'b0;
        drive(idle, 1'b0, 1'b1, 1'b0);
        m_addr = 12'h000; m_err = 0; exp_q.delete();
        @(negedge clk_i);
    endtask

    // Stream a list through; optional random consumer stalls.
    task automatic test_stream(input string name, input vec_t l[$], input bit stall);
        int idx = 0, cyc = 0, first_acc = -1, first_out = -1, last_out = -1, nout = 0;
        int budget;
        logic acc, oh, rdy;
        exp_t pe;
        logic [11:0] ae;
        budget = 4 * l.size() + 50;
        while ((idx < l.size() || exp_q.size() > 0) && cyc < budget) begin
            rdy = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            drive(l[(idx < l.size()) ? idx : 0], idx < l.size(), rdy, 1'b0);
            sample(l[(idx < l.size()) ? idx : 0], acc, oh, pe, ae);
            if (acc) begin
                if (first_acc < 0) first_acc = cyc;
                idx++;
            end
            if (oh) begin
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                nout++;
                n_vec++; if (instr_o !== pe.w) begin n_bad++; $display("FAIL %s instr got %h want %h", name, instr_o, pe.w); end
                n_vec++; if (err_o !== pe.e) begin n_bad++; $display("FAIL %s err got %b want %b (word %h)", name, err_o, pe.e, pe.w); end
                n_vec++; if (addr_o !== ae) begin n_bad++; $display("FAIL %s addr got %h want %h", name, addr_o, ae); end
            end
            @(negedge clk_i);
            cyc++;
        end
        drive(l[0], 1'b0, 1'b1, 1'b0);
        n_vec++; if (nout != l.size()) begin n_bad++; $display("FAIL %s count got %0d want %0d", name, nout, l.size()); end
        if (!stall) begin
            n_vec++; if (first_out - first_acc != 2) begin n_bad++; $display("FAIL %s latency got %0d want 2", name, first_out - first_acc); end
            n_vec++; if (last_out - first_out != l.size() - 1) begin n_bad++; $display("FAIL %s throughput span got %0d want %0d", name, last_out - first_out, l.size() - 1); end
        end
        #1;
        n_vec++; if (err_cnt_o !== 16'(m_err)) begin n_bad++; $display("FAIL %s errcnt got %0d want %0d", name, err_cnt_o, m_err); end
        @(negedge clk_i);
    endtask

    task automatic test_backpressure();
        vec_t l[$];
        int idx = 0, cyc = 0;
        logic acc, oh;
        exp_t pe;
        logic [11:0] ae;
        l.push_back(mk(ADDI, 1, 0, 0, 32'd5, 0, 32'h00500093, 1'b0));
        l.push_back(mk(ADD,  3, 1, 2, 32'd0, 0, 32'h002081B3, 1'b0));
        l.push_back(mk(SUB,  3, 1, 2, 32'd0, 0, 32'h402081B3, 1'b0));
        for (int i = 0; i < 2; i++) begin
            drive(l[i], 1'b1, 1'b0, 1'b0);
            sample(l[i], acc, oh, pe, ae);
            n_vec++; if (acc !== 1'b1) begin n_bad++; $display("FAIL bp_accept%0d got %b want 1", i, acc); end
            @(negedge clk_i);
        end
        for (int i = 0; i < 3; i++) begin
            drive(l[2], 1'b1, 1'b0, 1'b0);
            sample(l[2], acc, oh, pe, ae);
            n_vec++; if (in_ready_o !== 1'b0) begin n_bad++; $display("FAIL bp_stall_ready got %b want 0", in_ready_o); end
            n_vec++; if (out_valid_o !== 1'b1 || instr_o !== l[0].w) begin n_bad++; $display("FAIL bp_hold got v=%b %h want v=1 %h", out_valid_o, instr_o, l[0].w); end
            @(negedge clk_i);
        end
        idx = 2;
        while ((idx < 3 || exp_q.size() > 0) && cyc < 30) begin
            drive(l[(idx < 3) ? idx : 0], idx < 3, 1'b1, 1'b0);
            sample(l[(idx < 3) ? idx : 0], acc, oh, pe, ae);
            if (acc) idx++;
            if (oh) begin
                n_vec++; if (instr_o !== pe.w) begin n_bad++; $display("FAIL bp_drain instr got %h want %h", instr_o, pe.w); end
                n_vec++; if (addr_o !== ae) begin n_bad++; $display("FAIL bp_drain addr got %h want %h", addr_o, ae); end
            end
            @(negedge clk_i);
            cyc++;
        end
        n_vec++; if (idx != 3 || exp_q.size() != 0) begin n_bad++; $display("FAIL bp_complete got idx=%0d pending=%0d want 3/0", idx, exp_q.size()); end
        drive(l[0], 1'b0, 1'b1, 1'b0);
        @(negedge clk_i);
    endtask

    task automatic test_flush();
        vec_t v;
        logic acc, oh;
        exp_t pe;
        logic [11:0] ae, a_before;
        v = mk(ADDI, 1, 0, 0, 32'd1, 0, 32'h00100093, 1'b0);
        // Flush with no handshake: nothing counted, input not taken.
        for (int i = 0; i < 2; i++) begin
            drive(v, 1'b1, 1'b0, 1'b0); sample(v, acc, oh, pe, ae); @(negedge clk_i);
        end
        a_before = addr_o;
        drive(v, 1'b1, 1'b0, 1'b1);
        sample(v, acc, oh, pe, ae);
        n_vec++; if (in_ready_o !== 1'b0) begin n_bad++; $display("FAIL flush_in_ready got %b want 0", in_ready_o); end
        @(negedge clk_i);
        drive(v, 1'b0, 1'b1, 1'b0);
        #1;
        n_vec++; if (out_valid_o !== 1'b0) begin n_bad++; $display("FAIL flush_out_valid got %b want 0", out_valid_o); end
        n_vec++; if (addr_o !== a_before) begin n_bad++; $display("FAIL flush_addr got %h want %h", addr_o, a_before); end
        exp_q.delete();
        @(negedge clk_i);
        // Flush coinciding with a handshake: the consumed word still advances addr.
        for (int i = 0; i < 2; i++) begin
            drive(v, 1'b1, 1'b0, 1'b0); sample(v, acc, oh, pe, ae); @(negedge clk_i);
        end
        drive(v, 1'b1, 1'b1, 1'b1);
        sample(v, acc, oh, pe, ae);
        n_vec++; if (oh !== 1'b1 || instr_o !== pe.w) begin n_bad++; $display("FAIL flush_hs word got hs=%b %h want hs=1 %h", oh, instr_o, pe.w); end
        @(negedge clk_i);
        drive(v, 1'b0, 1'b1, 1'b0);
        #1;
        n_vec++; if (addr_o !== m_addr) begin n_bad++; $display("FAIL flush_hs_addr got %h want %h", addr_o, m_addr); end
        n_vec++; if (out_valid_o !== 1'b0) begin n_bad++; $display("FAIL flush_hs_valid got %b want 0", out_valid_o); end
        exp_q.delete();
        @(negedge clk_i);
    endtask

    task automatic test_reset_midstream();
        vec_t v;
        logic acc, oh;
        exp_t pe;
        logic [11:0] ae;
        v = mk(UNKNOWN, 1, 0, 0, 32'd0, 0, 32'h00000013, 1'b1);
        for (int i = 0; i < 2; i++) begin
            drive(v, 1'b1, 1'b0, 1'b0); sample(v, acc, oh, pe, ae); @(negedge clk_i);
        end
        #1;
        n_vec++; if (out_valid_o !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre_valid got %b want 1", out_valid_o); end
        rst_i = 1'b1;
        drive(v, 1'b1, 1'b1, 1'b0);
        #1;
        n_vec++; if (in_ready_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_in_ready got %b want 0", in_ready_o); end
        @(negedge clk_i);
        #1;
        n_vec++; if (out_valid_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid got %b want 0", out_valid_o); end
        n_vec++; if (addr_o !== 12'h000) begin n_bad++; $display("FAIL rstmid_addr got %h want 000", addr_o); end
        n_vec++; if (err_cnt_o !== 16'h0) begin n_bad++; $display("FAIL rstmid_errcnt got %0d want 0", err_cnt_o); end
        n_vec++; if (in_ready_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_in_ready2 got %b want 0", in_ready_o); end
        rst_i = 1'b0;
        drive(v, 1'b0, 1'b1, 1'b0);
        m_addr = 12'h000; m_err = 0; exp_q.delete();
        @(negedge clk_i);
    endtask

    initial begin
        vec_t basic[$], fmts[$], errs[$], wrap[$];
        basic.push_back(mk(ADDI, 1, 0, 0, 32'd5, 0, 32'h00500093, 1'b0));
        basic.push_back(mk(ADD,  3, 1, 2, 32'd0, 0, 32'h002081B3, 1'b0));
        basic.push_back(mk(SUB,  3, 1, 2, 32'd0, 0, 32'h402081B3, 1'b0));

        fmts.push_back(mk(SW,    7, 1, 2, 32'd8,         0, 32'h0020A423, 1'b0));
        fmts.push_back(mk(BEQ,   7, 1, 2, 32'd8,         0, 32'h00208463, 1'b0));
        fmts.push_back(mk(LUI,   2, 5, 6, 32'h12345000,  0, 32'h12345137, 1'b0));
        fmts.push_back(mk(SRAI,  5, 6, 9, 32'hFFFFFFFF,  3, 32'h40335293, 1'b0));
        fmts.push_back(mk(CLZ,   1, 2, 9, 32'd0,         0, 32'h60011093, 1'b0));
        fmts.push_back(mk(CTZ,   1, 2, 0, 32'd0,         0, 32'h60111093, 1'b0));
        fmts.push_back(mk(JAL,   1, 3, 4, 32'h00000800,  0, 32'h001000EF, 1'b0));
        fmts.push_back(mk(LW,    3, 1, 7, 32'hFFFFFFFC,  0, 32'hFFC0A183, 1'b0));
        fmts.push_back(mk(BNE,   0, 1, 2, 32'hFFFFFFF8,  0, 32'hFE209CE3, 1'b0));
        fmts.push_back(mk(AUIPC, 4, 0, 0, 32'h00001000,  0, 32'h00001217, 1'b0));

        errs.push_back(mk(ADDI,    1, 0, 0, 32'd2048, 0, 32'h80000093, 1'b1));
        errs.push_back(mk(BEQ,     0, 1, 2, 32'd7,    0, 32'h00208363, 1'b1));
        errs.push_back(mk(UNKNOWN, 1, 2, 3, 32'd0,    0, 32'h00000013, 1'b1));

        for (int i = 0; i < 1030; i++) wrap.push_back(mk(ADDI, 0, 0, 0, 32'd0, 0, 32'h00000013, 1'b0));

        test_reset();
        test_stream("basic", basic, 1'b0);
        test_stream("formats", fmts, 1'b0);
        test_backpressure();
        test_stream("formats_stall", fmts, 1'b1);
        test_flush();
        test_reset_midstream();
        test_stream("errors", errs, 1'b0);
        n_vec++; if (err_cnt_o !== 16'd3) begin n_bad++; $display("FAIL errors_errcnt3 got %0d want 3", err_cnt_o); end
        test_stream("addr_wrap", wrap, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
